// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage.
//
// Contents:
//   slot_state_e  fill state of one slot; the encoding doubles as the number
//                 of beats the slot holds (EMPTY=0, HALF=1, FULL=2)
//   OCC_W()       width of the occupancy count for a chain of 'stages' slots
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } slot_state_e;

    // Wide enough to count every beat a chain can hold (2 per slot).
    function automatic int OCC_W(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready streaming interface used on both sides of the pipeline stage.
//
// Signals:
//   data   payload, W bits
//   valid  beat present (driven by the producer)
//   ready  consumer can accept (driven by the consumer)
// Modports:
//   master  producer side: drives data/valid, samples ready
//   slave   consumer side: samples data/valid, drives ready
interface pipe_stage_skid_if #(
    parameter int W = 64
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/pipe_skid_slot.sv
// One register slot with a 2-entry skid (main + skid register).
//
// Ports:
//   clk, rst, flush        clock, synchronous reset, synchronous flush
//   up_valid/up_ready/up_data   upstream handshake (this slot consumes)
//   dn_valid/dn_ready/dn_data   downstream handshake (this slot produces)
//   fill                   number of beats held (0, 1 or 2)
//
// up_ready comes straight from the state register, so it never depends
// combinationally on dn_ready; the skid entry absorbs the one beat that can
// arrive in the cycle after downstream stalls.
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int           W       = 64,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data,
    output logic [1:0]   fill
);

    slot_state_e  state;
    logic [W-1:0] main_data;
    logic [W-1:0] skid_data;
    logic         take_in;
    logic         take_out;

    // main is valid in HALF and FULL, skid only in FULL.
    assign up_ready = (state != FULL);
    assign dn_valid = (state != EMPTY);
    assign dn_data  = main_data;
    assign fill     = state;

    assign take_in  = up_valid & up_ready;
    assign take_out = dn_valid & dn_ready;

    // Slot state machine. Reset and flush win over any same-cycle transfer.
    // Whenever main becomes empty its data register returns to CLR_VAL so
    // dn_data reads as CLR_VAL during bubbles without an output mux.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state     <= EMPTY;
            main_data <= CLR_VAL;
            skid_data <= CLR_VAL;
        end else begin
            case (state)
                EMPTY: begin
                    if (take_in) begin
                        state     <= HALF;
                        main_data <= up_data;
                    end
                end
                HALF: begin
                    if (take_in && !take_out) begin
                        state     <= FULL;
                        skid_data <= up_data;
                    end else if (take_in && take_out) begin
                        main_data <= up_data;
                    end else if (take_out) begin
                        state     <= EMPTY;
                        main_data <= CLR_VAL;
                    end
                end
                FULL: begin
                    // up_ready is low here, so only a drain can happen.
                    if (take_out) begin
                        state     <= HALF;
                        main_data <= skid_data;
                        skid_data <= CLR_VAL;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    main_data <= CLR_VAL;
                    skid_data <= CLR_VAL;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Parametrised inter-stage register: a chain of STAGES skid slots with a
// valid/ready handshake, flush and an occupancy count.
//
// Parameters:
//   W        payload width
//   STAGES   number of chained slots, legal range 1..8
//   CLR_VAL  value held by every data register after reset/flush and shown
//            on dn.data whenever dn.valid is low
// Ports:
//   clk        clock
//   rst        synchronous reset, active-high
//   flush      synchronous flush, active-high; drops every held beat
//   up         upstream stream (slave side): in_data/in_valid/in_ready
//   dn         downstream stream (master side): out_data/out_valid/out_ready
//   occupancy  total beats held across all slots
//
// With STAGES=1, dn.ready tied high and flush driven as the inverse of the
// old enable, this behaves as the legacy enable/clear register.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int           W       = 64,
    parameter int           STAGES  = 1,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    pipe_stage_skid_if.slave             up,
    pipe_stage_skid_if.master            dn,
    output logic [OCC_W(STAGES)-1:0]     occupancy
);

    localparam int OW = OCC_W(STAGES);

    // Link k sits in front of slot k; link STAGES is the chain output.
    logic         link_valid [STAGES+1];
    logic         link_ready [STAGES+1];
    logic [W-1:0] link_data  [STAGES+1];
    logic [1:0]   slot_fill  [STAGES];
    logic [OW-1:0] occ_sum;

    assign link_valid[0]      = up.valid;
    assign link_data[0]       = up.data;
    assign up.ready           = link_ready[0];
    assign dn.valid           = link_valid[STAGES];
    assign dn.data            = link_data[STAGES];
    assign link_ready[STAGES] = dn.ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_slot
        pipe_skid_slot #(
            .W       (W),
            .CLR_VAL (CLR_VAL)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .up_valid (link_valid[i]),
            .up_ready (link_ready[i]),
            .up_data  (link_data[i]),
            .dn_valid (link_valid[i+1]),
            .dn_ready (link_ready[i+1]),
            .dn_data  (link_data[i+1]),
            .fill     (slot_fill[i])
        );
    end

    // Each slot's fill is already a beat count, so occupancy is their sum.
    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_sum = occ_sum + OW'(slot_fill[i]);
        end
    end

    assign occupancy = occ_sum;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid. Three instances (STAGES=1,2,3)
// share the clock; each has its own stimulus. A monitor process keeps a
// reference FIFO per instance (filled on accepted input, drained on
// delivered output, emptied on reset/flush) and checks data, bubbles and
// occupancy every cycle. Directed checks are queued by the stimulus and
// evaluated by the same monitor at the next falling edge.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam logic [63:0] CLR2 = 64'h0000_0000_0000_C1C1;

    typedef enum int {K_VALID, K_DATA, K_READY, K_OCC} kind_e;
    typedef struct {
        int          dut;
        kind_e       kind;
        logic [63:0] exp;
    } chk_t;

    logic        clk = 1'b0;
    logic        rstv   [3];
    logic        flushv [3];
    logic        ivalid [3];
    logic [63:0] idata  [3];
    logic        oready [3];
    logic        iready [3];
    logic        ovalid [3];
    logic [63:0] odata  [3];
    logic [3:0]  occ    [3];

    logic [63:0] nextData [3];
    logic [63:0] q0 [$];
    logic [63:0] q1 [$];
    logic [63:0] q2 [$];
    chk_t        chkq [$];
    bit          known [3] = '{1'b0, 1'b0, 1'b0};
    int          vecs = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int          ST = g + 1;
        localparam logic [63:0] CV = (g == 2) ? CLR2 : 64'h0;
        pipe_stage_skid_if #(.W(64)) up_if ();
        pipe_stage_skid_if #(.W(64)) dn_if ();
        logic [OCC_W(ST)-1:0] occ_raw;

        assign up_if.valid = ivalid[g];
        assign up_if.data  = idata[g];
        assign iready[g]   = up_if.ready;
        assign ovalid[g]   = dn_if.valid;
        assign odata[g]    = dn_if.data;
        assign dn_if.ready = oready[g];
        assign occ[g]      = 4'(occ_raw);

        pipe_stage_skid #(
            .W       (64),
            .STAGES  (ST),
            .CLR_VAL (CV)
        ) dut (
            .clk       (clk),
            .rst       (rstv[g]),
            .flush     (flushv[g]),
            .up        (up_if),
            .dn        (dn_if),
            .occupancy (occ_raw)
        );
    end

    function automatic logic [63:0] clrOf(input int k);
        return (k == 2) ? CLR2 : 64'h0;
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [63:0] qfront(input int k);
        case (k)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    function automatic void qpush(input int k, input logic [63:0] d);
        case (k)
            0:       q0.push_back(d);
            1:       q1.push_back(d);
            default: q2.push_back(d);
        endcase
    endfunction

    function automatic void qpop(input int k);
        case (k)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endfunction

    function automatic void qclear(input int k);
        case (k)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endfunction

    // Monitor: directed checks first, then the per-cycle scoreboard for every
    // instance, then the model update for the edge that is about to happen.
    always @(negedge clk) begin
        chk_t        c;
        logic [63:0] act;
        string       nm;
        while (chkq.size() > 0) begin
            c = chkq.pop_front();
            case (c.kind)
                K_VALID: begin act = 64'(ovalid[c.dut]); nm = "out_valid"; end
                K_DATA:  begin act = odata[c.dut];       nm = "out_data";  end
                K_READY: begin act = 64'(iready[c.dut]); nm = "in_ready";  end
                default: begin act = 64'(occ[c.dut]);    nm = "occupancy"; end
            endcase
            vecs++;
            if (act !== c.exp) begin
                errs++;
                $display("[TB] FAIL dut%0d %s: got %h, want %h", c.dut, nm, act, c.exp);
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (known[k]) begin
                vecs++;
                if ($isunknown(occ[k]) || int'(occ[k]) != qsize(k)) begin
                    errs++;
                    $display("[TB] FAIL dut%0d occ_vs_model: got %0d, want %0d", k, occ[k], qsize(k));
                end
                vecs++;
                if (qsize(k) > 2 * (k + 1)) begin
                    errs++;
                    $display("[TB] FAIL dut%0d capacity: holds %0d, limit %0d", k, qsize(k), 2 * (k + 1));
                end
                if (ovalid[k] !== 1'b1) begin
                    vecs++;
                    if (ovalid[k] !== 1'b0 || odata[k] !== clrOf(k)) begin
                        errs++;
                        $display("[TB] FAIL dut%0d bubble: got valid=%b data=%h, want valid=0 data=%h", k, ovalid[k], odata[k], clrOf(k));
                    end
                end else begin
                    vecs++;
                    if (qsize(k) == 0) begin
                        errs++;
                        $display("[TB] FAIL dut%0d spurious_beat: got %h, want no beat", k, odata[k]);
                    end else if (odata[k] !== qfront(k)) begin
                        errs++;
                        $display("[TB] FAIL dut%0d beat_data: got %h, want %h", k, odata[k], qfront(k));
                    end
                end
            end
            if (rstv[k] || flushv[k]) begin
                qclear(k);
            end else begin
                if (ovalid[k] === 1'b1 && oready[k] && qsize(k) > 0) qpop(k);
                if (ivalid[k] && iready[k] === 1'b1) qpush(k, idata[k]);
            end
            if (rstv[k]) known[k] = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue a directed check; evaluated at the coming falling edge.
    task automatic checkOutput(input int k, input kind_e kind, input logic [63:0] exp);
        chkq.push_back('{dut: k, kind: kind, exp: exp});
    endtask

    task automatic checkResetState(input int k);
        checkOutput(k, K_VALID, 64'h0);
        checkOutput(k, K_DATA, clrOf(k));
        checkOutput(k, K_READY, 64'h1);
        checkOutput(k, K_OCC, 64'h0);
    endtask

    // One random cycle on the selected instances. A beat offered but not
    // accepted (and not killed by flush/reset) is held unchanged.
    task automatic applyStimulus(input bit [2:0] mask, input int fpct);
        bit hold [3];
        for (int k = 0; k < 3; k++) begin
            hold[k] = ivalid[k] && !iready[k] && !flushv[k] && !rstv[k];
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            if (mask[k]) begin
                flushv[k] = (int'($urandom_range(99)) < fpct);
                oready[k] = ($urandom_range(1) == 1);
                if (!hold[k]) begin
                    ivalid[k] = ($urandom_range(1) == 1);
                    if (ivalid[k]) begin
                        idata[k]    = nextData[k];
                        nextData[k] = nextData[k] + 64'h1;
                    end
                end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          n;
        logic        acc;
        logic        pen;
        logic [63:0] pd;

        for (int k = 0; k < 3; k++) begin
            rstv[k]     = 1'b1;
            flushv[k]   = 1'b0;
            ivalid[k]   = 1'b0;
            idata[k]    = 64'h0;
            oready[k]   = 1'b0;
            nextData[k] = 64'(k + 1) << 32;
        end

        // Reset values on every instance.
        tick();
        for (int k = 0; k < 3; k++) checkResetState(k);
        for (int k = 0; k < 3; k++) rstv[k] = 1'b0;
        tick();

        // Streaming through two slots: 1..8 back to back, 2-cycle latency.
        oready[1] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                ivalid[1] = 1'b1;
                idata[1]  = 64'(c + 1);
            end else begin
                ivalid[1] = 1'b0;
            end
            tick();
            checkOutput(1, K_VALID, 64'((c >= 1) && (c <= 8)));
            checkOutput(1, K_DATA, ((c >= 1) && (c <= 8)) ? 64'(c) : 64'h0);
            checkOutput(1, K_READY, 64'h1);
        end

        // Backpressure on a single slot.
        oready[0] = 1'b0;
        ivalid[0] = 1'b1;
        idata[0]  = 64'hA;
        tick();
        checkOutput(0, K_OCC, 64'd1);
        checkOutput(0, K_READY, 64'h1);
        checkOutput(0, K_DATA, 64'hA);
        idata[0] = 64'hB;
        tick();
        checkOutput(0, K_OCC, 64'd2);
        checkOutput(0, K_READY, 64'h0);
        checkOutput(0, K_DATA, 64'hA);
        ivalid[0] = 1'b0;
        tick();
        checkOutput(0, K_OCC, 64'd2);
        oready[0] = 1'b1;
        tick();
        checkOutput(0, K_DATA, 64'hB);
        checkOutput(0, K_OCC, 64'd1);
        checkOutput(0, K_READY, 64'h1);
        tick();
        checkOutput(0, K_VALID, 64'h0);
        checkOutput(0, K_OCC, 64'd0);
        checkOutput(0, K_READY, 64'h1);

        // Fill three slots, then flush while offering 0xDEAD.
        oready[2] = 1'b0;
        n = 0;
        for (int c = 0; c < 30 && n < 6; c++) begin
            ivalid[2] = 1'b1;
            idata[2]  = 64'h30 + 64'(n);
            acc       = iready[2];
            tick();
            if (acc) n++;
        end
        checkOutput(2, K_OCC, 64'd6);
        checkOutput(2, K_READY, 64'h0);
        flushv[2] = 1'b1;
        ivalid[2] = 1'b1;
        idata[2]  = 64'hDEAD;
        oready[2] = 1'b1;
        tick();
        flushv[2] = 1'b0;
        ivalid[2] = 1'b0;
        checkResetState(2);
        for (int c = 0; c < 4; c++) begin
            tick();
            checkOutput(2, K_VALID, 64'h0);
        end

        // Random traffic, one-cycle reset pulse, then a fresh stream.
        for (int c = 0; c < 30; c++) applyStimulus(3'b010, 0);
        rstv[1] = 1'b1;
        tick();
        rstv[1]   = 1'b0;
        ivalid[1] = 1'b0;
        checkResetState(1);
        nextData[1] = 64'h100;
        for (int c = 0; c < 40; c++) applyStimulus(3'b010, 0);
        ivalid[1] = 1'b0;
        oready[1] = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        checkOutput(1, K_OCC, 64'd0);
        checkOutput(1, K_VALID, 64'h0);

        // Legacy register: always loading, cleared to 0 when EN is low.
        oready[0] = 1'b1;
        ivalid[0] = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            flushv[0] = (int'($urandom_range(99)) < 20);
            idata[0]  = {$urandom, $urandom};
            pen       = !flushv[0];
            pd        = idata[0];
            tick();
            checkOutput(0, K_DATA, pen ? pd : 64'h0);
            checkOutput(0, K_VALID, 64'(pen));
        end
        flushv[0] = 1'b0;
        ivalid[0] = 1'b0;

        // Random soak on all three instances with frequent flushes.
        for (int c = 0; c < 600; c++) applyStimulus(3'b111, 20);
        for (int k = 0; k < 3; k++) begin
            flushv[k] = 1'b0;
            ivalid[k] = 1'b0;
            oready[k] = 1'b1;
        end
        for (int c = 0; c < 10; c++) tick();
        for (int k = 0; k < 3; k++) checkOutput(k, K_OCC, 64'd0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
